// File: rtl/imm4_packer.sv
// Packs 16-bit values that fit a 4-bit signed immediate into nibble lanes; out-of-range values are dropped and counted.
// Word appears the cycle after the 4th fitting accept or a flush; in_ready is low while the word waits for out_ready.
module imm4_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_count,
  output logic        ovf_err,
  output logic [7:0]  ovf_cnt
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]  state;
  logic [15:0] acc;
  logic [15:0] acc_nxt;
  logic [1:0]  lane_idx;
  logic [2:0]  cnt_nxt;
  logic        accept;
  logic        fits;
  logic        take;
  logic        drop;
  logic        emit;

  assign out_valid = (state == HOLD);
  assign in_ready  = ~out_valid;
  assign accept    = in_valid & in_ready;

  // A value fits in 4 signed bits when bits [15:3] are a pure sign extension.
  assign fits = (in_data[15:3] == 13'h0000) || (in_data[15:3] == 13'h1fff);
  assign take = accept & fits;
  assign drop = accept & ~fits;

  always_comb begin
    acc_nxt = acc;
    if (take) begin
      case (lane_idx)
        2'd0:    acc_nxt[3:0]   = in_data[3:0];
        2'd1:    acc_nxt[7:4]   = in_data[3:0];
        2'd2:    acc_nxt[11:8]  = in_data[3:0];
        default: acc_nxt[15:12] = in_data[3:0];
      endcase
    end
  end

  // Lane count after this cycle's input; flush sees the input taken in the same cycle.
  assign cnt_nxt = {1'b0, lane_idx} + {2'b00, take};
  assign emit    = (state == FILL) &&
                   ((cnt_nxt == 3'd4) || (flush && (cnt_nxt != 3'd0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      acc       <= 16'h0000;
      lane_idx  <= 2'd0;
      out_data  <= 16'h0000;
      out_count <= 3'd0;
      ovf_err   <= 1'b0;
      ovf_cnt   <= 8'd0;
    end else begin
      ovf_err <= drop;
      if (drop && (ovf_cnt != 8'hff)) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end

      if (state == FILL) begin
        if (emit) begin
          state     <= HOLD;
          out_data  <= acc_nxt;
          out_count <= cnt_nxt;
          acc       <= 16'h0000;
          lane_idx  <= 2'd0;
        end else begin
          acc      <= acc_nxt;
          lane_idx <= cnt_nxt[1:0];
        end
      end else if (out_ready) begin
        state <= FILL;
      end
    end
  end

endmodule
